lsu_ctrl: RTL and testbench

Load/store control unit sitting between the execute stage and `data_mem`, the 64×8 data RAM. It accepts one memory request at a time from the pipeline and computes the effective address as base plus signed offset. It range-checks that address and sequences byte accesses to the RAM, including 16-bit little-endian transfers split into two byte cycles. It returns a single-cycle response with load data or a fault flag.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_ctrl_if.sv | 32 +++
 rtl/lsu_ea_calc.sv | 16 +
 rtl/lsu_ctrl.sv | 141 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control unit.
// The data RAM behind the unit is 64 x 8.
package lsu_pkg;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 3'd0;
  localparam lsu_state_t ST_B0   = 3'd1;
  localparam lsu_state_t ST_B1   = 3'd2;
  localparam lsu_state_t ST_CAP  = 3'd3;
  localparam lsu_state_t ST_RSP  = 3'd4;

  localparam int         DMEM_LINES = 64;
  // First effective address that lies outside the RAM.
  localparam logic [7:0] EA_LIMIT   = 8'(DMEM_LINES);

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake plus data-RAM bus of the load/store unit.
// master = pipeline and RAM side, slave = lsu_ctrl.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_wide;
  logic [7:0]        req_base;
  logic [7:0]        req_offset;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic [15:0]       rsp_data;
  logic              rsp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_wide, req_base, req_offset, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_fault, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_write, req_wide, req_base, req_offset, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_fault, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/lsu_ea_calc.sv
// Effective address (base + signed offset, wrapping in 8 bits) and range check.
module lsu_ea_calc
  import lsu_pkg::*;
(
  input  logic [7:0] base,
  input  logic [7:0] offset,
  input  logic       wide,
  output logic [7:0] ea,
  output logic       fault
);

  // An 8-bit two's-complement add is exactly base + sext(offset) mod 256.
  assign ea    = base + offset;
  assign fault = (ea >= EA_LIMIT) || (wide && (ea == EA_LIMIT - 8'd1));

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: one request at a time, byte-sequenced access to the
// 64x8 data RAM, 16-bit transfers split little-endian over two byte cycles.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_ctrl_if.slave   bus
);

  logic [7:0]        ea;
  logic              ea_fault;

  lsu_state_t        state_q, state_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              rsp_fault_q, rsp_fault_d;
  logic [7:0]        ea_q, ea_d;
  logic              write_q, write_d;
  logic              wide_q, wide_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        lo_q, lo_d;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [7:0]        rd_byte;

  lsu_ea_calc u_ea_calc (
    .base   (bus.req_base),
    .offset (bus.req_offset),
    .wide   (bus.req_wide),
    .ea     (ea),
    .fault  (ea_fault)
  );

  assign rd_byte = 8'(bus.mem_rdata);

  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    ea_d        = ea_q;
    write_d     = write_q;
    wide_d      = wide_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ea_d    = ea;
          write_d = bus.req_write;
          wide_d  = bus.req_wide;
          wdata_d = bus.req_wdata;
          if (ea_fault) begin
            rsp_data_d  = 16'h0000;
            rsp_fault_d = 1'b1;
            state_d     = ST_RSP;
          end else begin
            state_d = ST_B0;
          end
        end
      end
      ST_B0: begin
        mem_addr  = ADDR_W'(ea_q);
        mem_we    = write_q;
        mem_wdata = write_q ? DATA_W'(wdata_q[7:0]) : '0;
        if (wide_q) begin
          state_d = ST_B1;
        end else if (write_q) begin
          rsp_data_d  = 16'h0000;
          rsp_fault_d = 1'b0;
          state_d     = ST_RSP;
        end else begin
          state_d = ST_CAP;
        end
      end
      ST_B1: begin
        mem_addr  = ADDR_W'(ea_q + 8'd1);
        mem_we    = write_q;
        mem_wdata = write_q ? DATA_W'(wdata_q[15:8]) : '0;
        if (write_q) begin
          rsp_data_d  = 16'h0000;
          rsp_fault_d = 1'b0;
          state_d     = ST_RSP;
        end else begin
          // Read data for the low byte (issued in B0) arrives now.
          lo_d    = rd_byte;
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        rsp_data_d  = wide_q ? {rd_byte, lo_q} : {8'h00, rd_byte};
        rsp_fault_d = 1'b0;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rsp_data_q  <= 16'h0000;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Request datapath: only meaningful after an accept, so no reset.
  always_ff @(posedge clk) begin
    ea_q    <= ea_d;
    write_q <= write_d;
    wide_q  <= wide_d;
    wdata_q <= wdata_d;
    lo_q    <= lo_d;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 64x8 synchronous-read RAM.
module tb_lsu_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   we_cnt;
  int   rsp_cnt;
  int   acc_cnt;
  logic [5:0] wa_last;
  logic [7:0] wd_last;
  logic [7:0] dmem [64] = '{default: 8'h00};

  lsu_ctrl_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  lsu_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= dmem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_cnt  <= we_cnt + 1;
      wa_last <= bus.mem_addr;
      wd_last <= bus.mem_wdata;
    end
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input bit w, input bit wide,
                        input logic [7:0] b, input logic [7:0] o, input logic [15:0] wd,
                        input int exp_lat, input bit chk_data, input logic [15:0] exp_data,
                        input bit exp_fault, input int exp_we);
    int lat;
    int we0;
    @(negedge clk);
    check({tag, ".ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_wide   = wide;
    bus.req_base   = b;
    bus.req_offset = o;
    bus.req_wdata  = wd;
    we0 = we_cnt;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_base   = 8'hFF;
    bus.req_offset = 8'h7F;
    bus.req_wdata  = 16'h5555;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".fault"}, 32'(bus.rsp_fault), 32'(exp_fault));
    if (chk_data) check({tag, ".data"}, 32'(bus.rsp_data), 32'(exp_data));
    check({tag, ".we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
    check({tag, ".ready_busy"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    int rsp0;
    int acc0;
    total = 0;
    bad = 0;
    we_cnt = 0;
    rsp_cnt = 0;
    acc_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_wide   = 1'b0;
    bus.req_base   = 8'h00;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 16'h0000;
    #12;
    check("rst.ready", 32'(bus.req_ready), 32'd1);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst.rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("rst.mem_we", 32'(bus.mem_we), 32'd0);
    check("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("st8", 1, 0, 8'h10, 8'h05, 16'h00A5, 2, 0, 16'h0000, 0, 1);
    check("st8.waddr", 32'(wa_last), 32'h15);
    check("st8.wdata", 32'(wd_last), 32'hA5);

    do_req("st16", 1, 1, 8'h20, 8'hFE, 16'hBEEF, 3, 0, 16'h0000, 0, 2);
    check("st16.lo", 32'(dmem[6'h1E]), 32'hEF);
    check("st16.hi", 32'(dmem[6'h1F]), 32'hBE);

    do_req("ld16", 0, 1, 8'h20, 8'hFE, 16'h0000, 4, 1, 16'hBEEF, 0, 0);
    do_req("ld8", 0, 0, 8'h1F, 8'h00, 16'h0000, 3, 1, 16'h00BE, 0, 0);
    do_req("st8_top", 1, 0, 8'h3F, 8'h00, 16'h775A, 2, 0, 16'h0000, 0, 1);
    do_req("flt_over", 0, 0, 8'h3F, 8'h01, 16'h0000, 1, 1, 16'h0000, 1, 0);
    do_req("flt_wide", 1, 1, 8'h3F, 8'h00, 16'hFFFF, 1, 1, 16'h0000, 1, 0);
    do_req("flt_wrap", 0, 0, 8'h02, 8'hFC, 16'h0000, 1, 1, 16'h0000, 1, 0);
    check("flt_wide.no_write", 32'(dmem[6'h3F]), 32'h5A);
    do_req("ld8_top", 0, 0, 8'h3F, 8'h00, 16'h0000, 3, 1, 16'h005A, 0, 0);
    do_req("ld16_edge", 0, 1, 8'h3E, 8'h00, 16'h0000, 4, 1, 16'h5A00, 0, 0);

    // Reset asserted during the high-byte cycle of a wide store.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_wide   = 1'b1;
    bus.req_base   = 8'h30;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 16'h1234;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort.b0_we", 32'(bus.mem_we), 32'd1);
    check("abort.b0_addr", 32'(bus.mem_addr), 32'h30);
    @(negedge clk);
    check("abort.b1_we", 32'(bus.mem_we), 32'd1);
    check("abort.b1_addr", 32'(bus.mem_addr), 32'h31);
    check("abort.b1_wdata", 32'(bus.mem_wdata), 32'h12);
    rst_n = 1'b0;
    #1;
    check("abort.we_drop", 32'(bus.mem_we), 32'd0);
    check("abort.ready", 32'(bus.req_ready), 32'd1);
    check("abort.addr", 32'(bus.mem_addr), 32'd0);
    check("abort.rsp_data", 32'(bus.rsp_data), 32'd0);
    rsp0 = rsp_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort.no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
    check("abort.lo_written", 32'(dmem[6'h30]), 32'h34);
    check("abort.hi_untouched", 32'(dmem[6'h31]), 32'h00);
    do_req("post_abort", 0, 0, 8'h30, 8'h00, 16'h0000, 3, 1, 16'h0034, 0, 0);

    // req_valid held high across two transactions with fields changing while busy.
    @(negedge clk);
    acc0 = acc_cnt;
    rsp0 = rsp_cnt;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_wide   = 1'b0;
    bus.req_base   = 8'h05;
    bus.req_offset = 8'h00;
    bus.req_wdata  = 16'h0011;
    @(posedge clk);
    #1;
    bus.req_base  = 8'h07;
    bus.req_wdata = 16'h0099;
    @(negedge clk);
    check("hold.busy_b0", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("hold.busy_rsp", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("hold.ready_again", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_base  = 8'h06;
    bus.req_wdata = 16'h0077;
    repeat (3) @(negedge clk);
    check("hold.accepts", 32'(acc_cnt - acc0), 32'd2);
    check("hold.responses", 32'(rsp_cnt - rsp0), 32'd2);
    check("hold.first", 32'(dmem[6'h05]), 32'h11);
    check("hold.second", 32'(dmem[6'h07]), 32'h99);
    check("hold.late_fields", 32'(dmem[6'h06]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
